// File: rtl/alu_multicycle.sv
// alu_multicycle: WIDTH-bit ALU with combinational single-cycle ops and an
// iterative multiply/divide engine that writes HI/LO after WIDTH cycles.
//
// Handshake: a mul/div transaction is accepted on the rising edge where
// start=1, alu_control holds a mul/div code and busy=0 (engine idle). busy is
// then high for exactly WIDTH cycles; done pulses for one cycle as HI/LO
// update. start seen while busy=1 is dropped, never queued.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MULT  = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  // busy is exactly (state_q == S_RUN), so the engine state is observable.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic             is_muldiv;
  logic             op_signed;
  logic             op_div;
  logic             launch;
  logic             last_step;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Engine registers: latched operands/flags and the shift accumulator pair.
  logic             div_q;
  logic             div0_q;
  logic             neg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH:0]   acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [SHW:0]     cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  // One-iteration next values and the sign-corrected final values.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  // Decode the operation class and form operand magnitudes for signed ops.
  always_comb begin
    is_muldiv = (alu_control == OP_MULT) || (alu_control == OP_MULTU) ||
                (alu_control == OP_DIV)  || (alu_control == OP_DIVU);
    op_signed = (alu_control == OP_MULT) || (alu_control == OP_DIV);
    op_div    = (alu_control == OP_DIV)  || (alu_control == OP_DIVU);
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
    launch    = (state_q == S_IDLE) && start && is_muldiv;
    last_step = (state_q == S_RUN) && (cnt_q == CNT_ONE);
  end

  // Single-cycle result; mul/div codes and the reserved code read as zero.
  always_comb begin
    result = '0;
    case (alu_control)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  result = a << b[SHW-1:0];
      OP_SRL:  result = a >> b[SHW-1:0];
      OP_SRA:  result = $unsigned($signed(a) >>> b[SHW-1:0]);
      default: result = '0;
    endcase
    zero = (result == '0);
  end

  // Engine state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Engine next-state: leave IDLE on an accepted launch, leave RUN on the last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_ONE) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One shift-add (multiply) or restoring shift-subtract (divide) iteration.
  // Multiply: {acc_hi, acc_lo} is the partial product with the multiplier
  // shifting out of acc_lo. Divide: acc_hi is the partial remainder, acc_lo
  // shifts the dividend out and the quotient bits in.
  always_comb begin
    mul_sum   = acc_lo_q[0] ? (acc_hi_q + {1'b0, opnd_q}) : acc_hi_q;
    div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    step_hi   = '0;
    step_lo   = '0;
    if (div_q) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff;
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift;
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = {1'b0, mul_sum[WIDTH:1]};
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied to the result of the final iteration.
  // MIN / -1 falls out naturally: magnitude quotient 2^(WIDTH-1) is MIN itself.
  always_comb begin
    prod     = {step_hi[WIDTH-1:0], step_lo};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo   = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (div0_q) begin
        fin_hi = a_q;
        fin_lo = '1;
      end else begin
        fin_lo = neg_q  ? (~step_lo + 1'b1) : step_lo;
        fin_hi = rneg_q ? (~step_hi[WIDTH-1:0] + 1'b1) : step_hi[WIDTH-1:0];
      end
    end
  end

  // Latch operands on launch, iterate while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= 1'b0;
      div0_q   <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      a_q      <= '0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else if (launch) begin
      div_q    <= op_div;
      div0_q   <= op_div && (b == '0);
      neg_q    <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      a_q      <= a;
      opnd_q   <= op_div ? b_mag : a_mag;
      acc_hi_q <= '0;
      acc_lo_q <= op_div ? a_mag : b_mag;
      cnt_q    <= CNT_INIT;
    end else if (state_q == S_RUN) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
      cnt_q    <= cnt_q - CNT_ONE;
    end
  end

  // HI/LO update and done pulse only on the completing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= last_step;
      if (last_step) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised execution unit for the datapath: a WIDTH-bit ALU that keeps the existing single-cycle operation set and encodings. It adds shifts, signed compare and XOR, and an iterative multiply/divide engine that writes dedicated HI/LO registers. Single-cycle operations produce `result` combinationally. Multiply and divide run as a start/busy/done multi-cycle transaction, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, 32: operand/result width. Must be a power of two and ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a`  in  WIDTH  operand A (rs).
- `b`  in  WIDTH  operand B (rt/immediate).
- `alu_control`  in  4  operation select.
- `start`  in  1  launch a mul/div op; sampled only when `alu_control` is a mul/div code and `busy`=0.
- `result`  out  WIDTH  combinational result of a single-cycle op.
- `zero`  out  1  `result == 0`.
- `busy`  out  1  mul/div engine iterating.
- `done`  out  1  one-cycle pulse when HI/LO have been updated.
- `hi`  out  WIDTH  HI register: upper product half, or remainder.
- `lo`  out  WIDTH  LO register: lower product half, or quotient.

## Operation
- Single-cycle ops (`result`, pure combinational, no dependence on `start` or engine state):
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (both wrap mod 2^WIDTH, no overflow flag).
  - 0011 XOR; 1100 NOR.
  - 0111 SLTU (unsigned a<b → 1, else 0); 1000 SLT (two's-complement compare).
  - 0100 SLL: a << b[SHW-1:0]. 0101 SRL: logical a >> b[SHW-1:0]. 1001 SRA: arithmetic shift.
- Mul/div codes: 1010 MULT, 1011 MULTU, 1101 DIV, 1110 DIVU. While one of these is selected, `result`=0 and `zero`=1.
- Code 1111 is reserved: `result`=0.
- Engine FSM has two states, IDLE and RUN.
  - IDLE→RUN when `start`=1 and `alu_control` is a mul/div code. The op, a and b are latched and the iteration counter is set to WIDTH.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, counter decrements.
  - RUN→IDLE when the counter reaches 0. HI/LO are written on that edge and `done` pulses.
- Signed ops (MULT, DIV) operate on magnitudes and fix the sign at the end:
  - Product sign = sign(a) XOR sign(b).
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
- Full 2·WIDTH product: HI = upper half, LO = lower half.
- Divide by zero, signed or unsigned: LO = all ones, HI = a. Latency is the same as a normal divide.
- Signed overflow (DIV of MIN by −1): LO = MIN, HI = 0.
- HI/LO hold their value until the next completion. Intermediate values are never visible on `hi`/`lo`.

## Timing
- Reset (async, `rst_n`=0): FSM→IDLE, counter=0, `busy`=0, `done`=0, `hi`=0, `lo`=0. `result`/`zero` follow the inputs.
- Reset during RUN aborts the operation: HI/LO are cleared to 0, not left with partial results.
- `start` is sampled at edge E0.
  - `busy`=1 from after E0 through edge E0+WIDTH.
  - After edge E0+WIDTH: `busy`=0, `done`=1, `hi`/`lo` valid.
  - `done` clears after the next edge.
  - Total latency is WIDTH cycles, fixed for all four ops and all operand values.
- `start` while `busy`=1 is ignored; it is not queued.
- `start` in the cycle `done`=1 is accepted, since the engine is in IDLE. This gives back-to-back ops at a WIDTH-cycle throughput.
- `start` with a non-mul/div `alu_control` is ignored.
- Operand inputs may change freely during RUN; only the values latched at E0 are used.
- Single-cycle ops remain fully usable while the engine is busy.

## Test plan
- ADD/SUB/SLTU/SLT, WIDTH=32:
  - a=0xFFFFFFFF, b=1 → ADD 0, `zero`=1.
  - SUB 0xFFFFFFFE.
  - SLTU 0.
  - SLT 1.
- Shifts: a=0x80000001, b=0x24 (shift by 4) → SLL 0x00000010; SRL 0x08000000; SRA 0xF8000000.
- MULT a=−3, b=7 → `busy` high for 32 cycles, then `done` pulses once; HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU with the same operands → HI=0x00000006, LO=0xFFFFFFEB.
- DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=0 → LO=0xFFFFFFFF, HI=7. DIV 0x80000000 by −1 → LO=0x80000000, HI=0.
- Handshake: a second `start` at cycle 5 of RUN is ignored, and HI/LO reflect the first op. A new `start` in the `done` cycle launches an op that completes exactly 32 cycles later.
- `rst_n` pulsed low mid-RUN (cycle 10) → `busy`/`done`/`hi`/`lo` go to 0 immediately, with no `done` afterward; the next `start` completes normally.
